// File: rtl/prueba2.sv
// prueba2: PS/2 host controller for a pointing device.
// Sends CMD_BYTE on a tx_write edge, waits for ACK_BYTE, then streams
// correctly framed device bytes out on DatoRec with an rx_done strobe.
module prueba2 #(
    parameter logic [7:0]  CMD_BYTE       = 8'hF4,
    parameter logic [7:0]  ACK_BYTE       = 8'hFA,
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       tx_write,
    inout  wire        PS2CLK,
    inout  wire        PS2DATA,
    output logic       STREAM,
    output logic       FAIL,
    output logic [7:0] DatoRec,
    output logic [7:0] dataout,
    output logic       rx_done
);

    localparam int unsigned MAX_CNT = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                       : INHIBIT_CYCLES;
    localparam int CNT_W = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_TX, S_TX_ACK, S_RX_ACK, S_STREAM, S_FAIL
    } state_t;

    // Odd parity bit: makes the total number of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
    logic             dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic             txw_q, txw_d;
    logic             clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
    logic [3:0]       tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
    logic [9:0]       rx_sr_q, rx_sr_d;
    logic [7:0]       dato_q, dato_d, dout_q, dout_d;
    logic             rx_done_q, rx_done_d;

    logic             clk_in, dat_in, fall, txw_rise, timeout, rx_last, frame_ok;
    logic [10:0]      frame;
    logic [7:0]       rx_byte;
    logic             rx_step, go_fail;

    // Open-drain pads: only ever pull low, otherwise release to the pull-up.
    assign PS2CLK  = clk_oe_q ? 1'b0 : 1'bz;
    assign PS2DATA = dat_oe_q ? 1'b0 : 1'bz;

    // Anything other than a solid 0 (including a floating line) reads as high.
    assign clk_in   = (PS2CLK == 1'b0) ? 1'b0 : 1'b1;
    assign dat_in   = (PS2DATA == 1'b0) ? 1'b0 : 1'b1;

    assign fall     = clk_prev_q & ~clk_s2_q;
    assign txw_rise = tx_write & ~txw_q;
    assign timeout  = (cnt_q == TO_LAST);
    assign rx_last  = (rx_idx_q == 4'd10);
    // Frame in arrival order: bit0 start, bits 8:1 data LSB first, bit9 parity, bit10 stop.
    assign frame    = {dat_s2_q, rx_sr_q};
    assign rx_byte  = frame[8:1];
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

    assign STREAM  = (state_q == S_STREAM);
    assign FAIL    = (state_q == S_FAIL);
    assign DatoRec = dato_q;
    assign dataout = dout_q;
    assign rx_done = rx_done_q;

    // Next-state, line drive and receive datapath.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        clk_s1_d   = clk_in;
        clk_s2_d   = clk_s1_q;
        clk_prev_d = clk_s2_q;
        dat_s1_d   = dat_in;
        dat_s2_d   = dat_s1_q;
        txw_d      = tx_write;
        clk_oe_d   = clk_oe_q;
        dat_oe_d   = dat_oe_q;
        tx_idx_d   = tx_idx_q;
        rx_idx_d   = rx_idx_q;
        rx_sr_d    = rx_sr_q;
        dato_d     = dato_q;
        dout_d     = dout_q;
        rx_done_d  = 1'b0;
        rx_step    = 1'b0;
        go_fail    = 1'b0;

        case (state_q)
            S_IDLE: cnt_d = '0;
            S_INHIBIT: begin
                // Release the clock and pull data low in the same cycle (request-to-send).
                if (cnt_q == INH_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                    state_d  = S_REQ;
                    cnt_d    = '0;
                end
            end
            S_REQ: begin
                state_d  = S_TX;
                cnt_d    = '0;
                tx_idx_d = '0;
            end
            S_TX: begin
                if (fall) begin
                    cnt_d    = '0;
                    tx_idx_d = tx_idx_q + 1'b1;
                    if (tx_idx_q < 4'd8) begin
                        dat_oe_d = ~dout_q[tx_idx_q[2:0]];
                    end else if (tx_idx_q == 4'd8) begin
                        dat_oe_d = ~odd_parity(dout_q);
                    end else begin
                        dat_oe_d = 1'b0;
                        state_d  = S_TX_ACK;
                    end
                end else if (timeout) begin
                    go_fail = 1'b1;
                end
            end
            S_TX_ACK: begin
                if (fall) begin
                    cnt_d = '0;
                    if (!dat_s2_q) begin
                        state_d  = S_RX_ACK;
                        rx_idx_d = '0;
                    end else begin
                        go_fail = 1'b1;
                    end
                end else if (timeout) begin
                    go_fail = 1'b1;
                end
            end
            S_RX_ACK: begin
                if (fall) begin
                    rx_step = 1'b1;
                    if (rx_last) begin
                        state_d = (frame_ok && (rx_byte == ACK_BYTE)) ? S_STREAM : S_FAIL;
                    end
                end else if (timeout) begin
                    go_fail = 1'b1;
                end
            end
            S_STREAM: begin
                // A stalled device drops the partial frame; stream mode persists.
                if (fall) begin
                    rx_step = 1'b1;
                end else if (timeout) begin
                    cnt_d    = '0;
                    rx_idx_d = '0;
                end
            end
            S_FAIL:  cnt_d = '0;
            default: state_d = S_IDLE;
        endcase

        if (rx_step) begin
            cnt_d   = '0;
            rx_sr_d = frame[10:1];
            if (rx_last) begin
                rx_idx_d = '0;
                if (frame_ok) begin
                    dato_d    = rx_byte;
                    rx_done_d = 1'b1;
                end
            end else begin
                rx_idx_d = rx_idx_q + 1'b1;
            end
        end

        if (go_fail) begin
            state_d  = S_FAIL;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            cnt_d    = '0;
        end

        if (txw_rise && (state_q == S_IDLE || state_q == S_STREAM || state_q == S_FAIL)) begin
            state_d  = S_INHIBIT;
            cnt_d    = '0;
            clk_oe_d = 1'b1;
            dat_oe_d = 1'b0;
            dout_d   = CMD_BYTE;
            tx_idx_d = '0;
            rx_idx_d = '0;
        end
    end

    // State and datapath registers; reset releases both lines at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            txw_q      <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            tx_idx_q   <= '0;
            rx_idx_q   <= '0;
            rx_sr_q    <= '0;
            dato_q     <= '0;
            dout_q     <= '0;
            rx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            clk_prev_q <= clk_prev_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
            txw_q      <= txw_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            tx_idx_q   <= tx_idx_d;
            rx_idx_q   <= rx_idx_d;
            rx_sr_q    <= rx_sr_d;
            dato_q     <= dato_d;
            dout_q     <= dout_d;
            rx_done_q  <= rx_done_d;
        end
    end

endmodule

// File: tb/tb_prueba2.sv
// tb_prueba2: device-side model of a PS/2 mouse driving prueba2.
module tb_prueba2;

    localparam int         INH  = 5000;
    localparam int         TOUT = 3000;
    localparam int         H    = 20;
    localparam logic [7:0] CMD  = 8'hF4;
    localparam logic [7:0] ACK  = 8'hFA;

    logic       CLK;
    logic       RST;
    logic       tx_write;
    wire        PS2CLK;
    wire        PS2DATA;
    logic       STREAM;
    logic       FAIL;
    logic [7:0] DatoRec;
    logic [7:0] dataout;
    logic       rx_done;

    bit dev_clk_low;
    bit dev_dat_low;

    pullup (PS2CLK);
    pullup (PS2DATA);
    assign PS2CLK  = dev_clk_low ? 1'b0 : 1'bz;
    assign PS2DATA = dev_dat_low ? 1'b0 : 1'bz;

    prueba2 #(
        .CMD_BYTE(CMD), .ACK_BYTE(ACK),
        .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .CLK(CLK), .RST(RST), .tx_write(tx_write),
        .PS2CLK(PS2CLK), .PS2DATA(PS2DATA),
        .STREAM(STREAM), .FAIL(FAIL), .DatoRec(DatoRec),
        .dataout(dataout), .rx_done(rx_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit prev_done = 1'b0;
    bit dbl_seen = 1'b0;
    bit both_seen = 1'b0;

    // Count rx_done strobes and watch for illegal output combinations.
    always @(negedge CLK) begin
        if (rx_done) done_cnt <= done_cnt + 1;
        if (rx_done && prev_done) dbl_seen <= 1'b1;
        prev_done <= rx_done;
        if (STREAM && FAIL) both_seen <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wcyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Reference: 11-bit PS/2 frame built from the protocol rules, optionally with bad parity.
    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad);
        int   ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        if (bad) par = ~par;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic tx_pulse();
        tx_write = 1'b1;
        wcyc(2);
        tx_write = 1'b0;
    endtask

    task automatic dev_wait_req(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge CLK);
            #1;
            if (PS2CLK == 1'b1 && PS2DATA == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Device clocks nclk host bits in (sampled while clock is low), optionally acknowledges.
    task automatic dev_get_cmd(input bit ack, input int nclk, output logic [9:0] bits);
        bits = '0;
        for (int i = 0; i < nclk; i++) begin
            wcyc(H);
            dev_clk_low = 1'b1;
            wcyc(H);
            bits[i] = PS2DATA;
            dev_clk_low = 1'b0;
        end
        if (ack) begin
            wcyc(H / 2);
            dev_dat_low = 1'b1;
            wcyc(H / 2);
            dev_clk_low = 1'b1;
            wcyc(H);
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
            wcyc(2 * H);
        end
    endtask

    task automatic dev_send_frame(input logic [7:0] b, input bit bad, input int nbits);
        logic [10:0] f;
        f = frame_bits(b, bad);
        for (int i = 0; i < nbits; i++) begin
            dev_dat_low = ~f[i];
            wcyc(H);
            dev_clk_low = 1'b1;
            wcyc(H);
            dev_clk_low = 1'b0;
        end
        dev_dat_low = 1'b0;
        wcyc(2 * H);
    endtask

    // Full command handshake: request, clock command in, ack, reply.
    task automatic handshake(input logic [7:0] reply, input string tag);
        bit          found;
        logic [9:0]  bits;
        logic [10:0] ref_f;
        dev_wait_req(found);
        chk({tag, "_req_seen"}, 32'(found), 32'd1);
        dev_get_cmd(1'b1, 10, bits);
        ref_f = frame_bits(CMD, 1'b0);
        chk({tag, "_cmd_bits"}, 32'(bits), 32'(ref_f[10:1]));
        dev_send_frame(reply, 1'b0, 11);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        int         exp_done;
        logic [7:0] exp_dato;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int          n;
        int          d0;
        bit          found;
        logic [9:0]  bits;
        logic [7:0]  rb;
        bit          rbad;
        logic [7:0]  exp_dato;

        tbl[0] = '{8'h08, 1'b0, 1, 8'h08};
        tbl[1] = '{8'h05, 1'b0, 1, 8'h05};
        tbl[2] = '{8'hFB, 1'b0, 1, 8'hFB};
        tbl[3] = '{8'h3C, 1'b1, 0, 8'hFB};
        tbl[4] = '{8'h00, 1'b0, 1, 8'h00};
        tbl[5] = '{8'hFF, 1'b1, 0, 8'h00};
        tbl[6] = '{8'h81, 1'b0, 1, 8'h81};

        tx_write    = 1'b0;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        RST         = 1'b0;
        wcyc(5);
        chk("rst_stream", 32'(STREAM), 32'd0);
        chk("rst_fail", 32'(FAIL), 32'd0);
        chk("rst_datorec", 32'(DatoRec), 32'h00);
        chk("rst_dataout", 32'(dataout), 32'h00);
        chk("rst_rx_done", 32'(rx_done), 32'd0);
        chk("rst_lines", {30'd0, PS2CLK, PS2DATA}, 32'b11);
        RST = 1'b1;
        wcyc(5);

        // No device: inhibit timing, request, then timeout to FAIL.
        tx_write = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            wcyc(1);
            n++;
            if (PS2CLK == 1'b0) break;
        end
        tx_write = 1'b0;
        chk("inhibit_latency_ok", 32'(n >= 1 && n <= 2), 32'd1);
        n = 1;
        for (int i = 0; i < INH + 100; i++) begin
            wcyc(1);
            if (PS2CLK == 1'b0) n++;
            else break;
        end
        chk("inhibit_len", 32'(n), 32'(INH));
        chk("req_data_low", 32'(PS2DATA), 32'd0);
        n = 0;
        for (int i = 0; i < TOUT + 200; i++) begin
            wcyc(1);
            n++;
            if (FAIL) break;
        end
        chk("nodev_fail", 32'(FAIL), 32'd1);
        chk("nodev_timeout_window", 32'(n >= TOUT - 1 && n <= TOUT + 3), 32'd1);
        chk("nodev_stream", 32'(STREAM), 32'd0);
        chk("nodev_dataout", 32'(dataout), 32'(CMD));
        chk("nodev_lines_released", {30'd0, PS2CLK, PS2DATA}, 32'b11);

        // Successful handshake from FAIL.
        d0 = done_cnt;
        tx_pulse();
        handshake(ACK, "ok");
        chk("ok_stream", 32'(STREAM), 32'd1);
        chk("ok_fail", 32'(FAIL), 32'd0);
        chk("ok_datorec", 32'(DatoRec), 32'(ACK));
        chk("ok_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Table-driven stream traffic.
        for (int i = 0; i < 7; i++) begin
            d0 = done_cnt;
            dev_send_frame(tbl[i].data, tbl[i].bad_par, 11);
            chk($sformatf("tbl%0d_done", i), 32'(done_cnt - d0), 32'(tbl[i].exp_done));
            chk($sformatf("tbl%0d_dato", i), 32'(DatoRec), 32'(tbl[i].exp_dato));
            chk($sformatf("tbl%0d_stream", i), 32'(STREAM), 32'd1);
        end

        // Partial frame then stall: discarded after the timeout, next frame clean.
        exp_dato = tbl[6].exp_dato;
        d0 = done_cnt;
        dev_send_frame(8'hA5, 1'b0, 5);
        wcyc(TOUT + 100);
        chk("stall_no_done", 32'(done_cnt - d0), 32'd0);
        chk("stall_stream", 32'(STREAM), 32'd1);
        dev_send_frame(8'h5A, 1'b0, 11);
        chk("after_stall_done", 32'(done_cnt - d0), 32'd1);
        chk("after_stall_dato", 32'(DatoRec), 32'h5A);
        exp_dato = 8'h5A;

        // Randomized stream bytes against the frame-rule model.
        for (int i = 0; i < 10; i++) begin
            rb   = 8'($urandom_range(0, 255));
            rbad = ($urandom_range(0, 3) == 0);
            d0   = done_cnt;
            dev_send_frame(rb, rbad, 11);
            if (!rbad) exp_dato = rb;
            chk($sformatf("rnd%0d_done_%02h", i, rb), 32'(done_cnt - d0), 32'(!rbad));
            chk($sformatf("rnd%0d_dato", i), 32'(DatoRec), 32'(exp_dato));
        end

        // Wrong reply, with tx_write held high throughout.
        tx_write = 1'b1;
        wcyc(5);
        chk("restart_clears_stream", 32'(STREAM), 32'd0);
        handshake(8'hFE, "fe");
        chk("fe_fail", 32'(FAIL), 32'd1);
        chk("fe_stream", 32'(STREAM), 32'd0);
        chk("fe_datorec", 32'(DatoRec), 32'hFE);
        wcyc(200);
        chk("held_txw_single_start", 32'(PS2CLK), 32'd1);
        chk("held_txw_fail_holds", 32'(FAIL), 32'd1);
        tx_write = 1'b0;
        wcyc(5);

        // Reset in the middle of the command transfer.
        tx_pulse();
        dev_wait_req(found);
        chk("midtx_req_seen", 32'(found), 32'd1);
        dev_get_cmd(1'b0, 4, bits);
        chk("midtx_bits", 32'(bits[3:0]), 32'(CMD[2:0]) | 32'h0);
        chk("midtx_data_driven", 32'(PS2DATA), 32'(CMD[3]));
        RST = 1'b0;
        #1;
        chk("midtx_rst_lines", {30'd0, PS2CLK, PS2DATA}, 32'b11);
        chk("midtx_rst_outs", {14'd0, STREAM, FAIL, DatoRec, dataout}, 32'h0);
        wcyc(5);
        RST = 1'b1;
        wcyc(5);
        d0 = done_cnt;
        tx_pulse();
        handshake(ACK, "again");
        chk("again_stream", 32'(STREAM), 32'd1);
        chk("again_datorec", 32'(DatoRec), 32'(ACK));
        chk("again_done", 32'(done_cnt - d0), 32'd1);

        chk("rx_done_single_cycle", 32'(dbl_seen), 32'd0);
        chk("stream_fail_exclusive", 32'(both_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
